// File: rtl/num_to_str_pkg.sv
// Shared types and constants for the binary-to-ASCII-decimal serialiser.
package num_to_str_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SEND    = 2'd2,
        TERM    = 2'd3
    } state_t;

    localparam int         NUM_DIGITS = 10;
    localparam int         BCD_W      = 40;
    localparam int         BIN_W      = 32;
    localparam int         CNT_W      = 5;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    // Index of the most significant nonzero BCD digit; 0 when all digits are zero.
    function automatic logic [3:0] msd_index(input logic [BCD_W-1:0] bcd);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/num_to_str_dd_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift {bcd,bin} left by one.
module dd_bin_to_bcd_step
    import num_to_str_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic [BCD_W-1:0] bcd_o,
    output logic [BIN_W-1:0] bin_o
);

    logic [BCD_W-1:0] adj;

    always_comb begin
        adj = bcd_i;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_i[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
        end
    end

    assign bcd_o = {adj[BCD_W-2:0], bin_i[BIN_W-1]};
    assign bin_o = {bin_i[BIN_W-2:0], 1'b0};

endmodule

// File: rtl/num_to_str.sv
// Converts a 32-bit unsigned number to an MSD-first ASCII decimal stream with
// leading zeros suppressed and an optional terminator byte.
module num_to_str
    import num_to_str_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR = 8'h0A,
    parameter bit         EMIT_TERM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] n_dtm,
    input  logic        n_vld,
    output logic        n_rdy,
    output logic [7:0]  s_dtm,
    output logic        s_vld,
    input  logic        s_rdy,
    output state_t      dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // s_vld/s_dtm depend only on state and hold while s_rdy is low, n_rdy only on state.

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_step;
    logic [BIN_W-1:0]   bin_q, bin_d, bin_step;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [3:0]         cur_digit;

    dd_bin_to_bcd_step u_step (
        .bcd_i (bcd_q),
        .bin_i (bin_q),
        .bcd_o (bcd_step),
        .bin_o (bin_step)
    );

    assign cur_digit = bcd_q[{ptr_q, 2'b00} +: 4];
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        n_rdy   = 1'b0;
        s_vld   = 1'b0;
        s_dtm   = 8'h00;
        case (state_q)
            IDLE: begin
                n_rdy = 1'b1;
                if (n_vld) begin
                    bin_d   = n_dtm;
                    bcd_d   = '0;
                    cnt_d   = 5'd31;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d = bcd_step;
                bin_d = bin_step;
                cnt_d = cnt_q - 5'd1;
                // Last bit shifted in this cycle; bcd_step already holds the final digits.
                if (cnt_q == 5'd0) begin
                    state_d = SEND;
                    ptr_d   = msd_index(bcd_step);
                end
            end
            SEND: begin
                s_vld = 1'b1;
                s_dtm = ASCII_ZERO | {4'h0, cur_digit};
                if (s_rdy) begin
                    if (ptr_q != 4'd0) ptr_d = ptr_q - 4'd1;
                    else               state_d = EMIT_TERM ? TERM : IDLE;
                end
            end
            TERM: begin
                s_vld = 1'b1;
                s_dtm = TERM_CHAR;
                if (s_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_num_to_str.sv
// Bench for num_to_str: decimal strings from $sformatf, randomized values and sink stalls.
module tb_num_to_str;
  import num_to_str_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] n_dtm, n2_dtm;
  logic        n_vld, n2_vld;
  logic        n_rdy, n2_rdy;
  logic [7:0]  s_dtm, s2_dtm;
  logic        s_vld, s2_vld;
  logic        s_rdy, s2_rdy;
  state_t      dbg_state, dbg_state2;

  logic [7:0]  exp_q[$];
  logic [7:0]  exp2_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  num_to_str #(.TERM_CHAR(8'h0A), .EMIT_TERM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .n_dtm(n_dtm), .n_vld(n_vld), .n_rdy(n_rdy),
    .s_dtm(s_dtm), .s_vld(s_vld), .s_rdy(s_rdy),
    .dbg_state(dbg_state)
  );

  num_to_str #(.TERM_CHAR(8'h0A), .EMIT_TERM(1'b0)) dut_nt (
    .clk(clk), .rst_n(rst_n),
    .n_dtm(n2_dtm), .n_vld(n2_vld), .n_rdy(n2_rdy),
    .s_dtm(s2_dtm), .s_vld(s2_vld), .s_rdy(s2_rdy),
    .dbg_state(dbg_state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: decimal text of the value plus optional newline
  task automatic expect_num(input logic [31:0] v, input bit term);
    string s;
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    if (term) exp_q.push_back(8'h0A);
  endtask

  // called at a negedge; returns right after the accepting rising edge
  task automatic offer(input logic [31:0] v);
    int waited;
    waited = 0;
    n_dtm = v;
    n_vld = 1'b1;
    while (!n_rdy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("n_accept_timeout", 32'(waited < 100), 32'd1);
    @(posedge clk);
  endtask

  // collect characters until the expected queue empties
  task automatic drain(input bit rand_rdy);
    int         cyc;
    bit         prev_stall;
    logic [7:0] prev_dtm;
    cyc = 0;
    prev_stall = 1'b0;
    prev_dtm = 8'h00;
    while (exp_q.size() > 0 && cyc < 400) begin
      s_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("s_vld_busy", s_vld, 1);
      chk("n_rdy_busy", n_rdy, 0);
      if (prev_stall) chk("stall_stable_dtm", s_dtm, prev_dtm);
      if (s_vld && s_rdy) chk("char", s_dtm, exp_q.pop_front());
      prev_stall = s_vld && !s_rdy;
      prev_dtm = s_dtm;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("drain_timeout", 32'(cyc < 400), 32'd1);
    exp_q.delete();
    chk("n_rdy_after_last", n_rdy, 1);
    chk("s_vld_after_last", s_vld, 0);
  endtask

  task automatic run_num(input logic [31:0] v, input bit rand_rdy, input bit hold_vld,
                         input logic [31:0] busy_dtm);
    int lat;
    expect_num(v, 1'b1);
    offer(v);
    lat = 0;
    @(negedge clk);
    lat++;
    if (hold_vld) n_dtm = busy_dtm;
    else begin
      n_vld = 1'b0;
      n_dtm = $urandom;
    end
    while (!s_vld && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    // lat counts rising edges including the accepting one
    chk("first_char_latency", lat, 33);
    chk("n_rdy_convert", n_rdy, 0);
    drain(rand_rdy);
  endtask

  task automatic run_nt(input logic [31:0] v);
    string s;
    int    cyc, got;
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) exp2_q.push_back(s[i]);
    n2_dtm = v;
    n2_vld = 1'b1;
    cyc = 0;
    while (!n2_rdy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    @(negedge clk);
    n2_vld = 1'b0;
    cyc = 0;
    while (!s2_vld && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("nt_first_char_seen", s2_vld, 1);
    cyc = 0;
    got = 0;
    while (s2_vld && cyc < 20) begin
      if (exp2_q.size() > 0) chk("nt_char", s2_dtm, exp2_q.pop_front());
      got++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("nt_byte_count", got, s.len());
    chk("nt_n_rdy_after", n2_rdy, 1);
    exp2_q.delete();
  endtask

  initial begin
    logic [31:0] v;
    int          w;
    rst_n = 1'b0;
    n_dtm = '0;  n_vld = 1'b0;  s_rdy = 1'b0;
    n2_dtm = '0; n2_vld = 1'b0; s2_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_n_rdy", n_rdy, 1);
    chk("rst_s_vld", s_vld, 0);
    chk("rst_s_dtm", s_dtm, 8'h00);
    chk("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    s_rdy = 1'b1;
    run_num(32'd0, 1'b0, 1'b0, 32'd0);
    run_num(32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
    run_num(32'd1000, 1'b0, 1'b0, 32'd0);

    run_nt(32'd7);
    run_nt($urandom_range(0, 99999));

    run_num(32'd305419896, 1'b1, 1'b0, 32'd0);

    // back-to-back: n_vld stays high, n_dtm switches to 9 while 42 is busy
    run_num(32'd42, 1'b0, 1'b1, 32'd9);
    run_num(32'd9, 1'b0, 1'b0, 32'd0);

    for (int k = 0; k < 8; k++) begin
      v = $urandom >> $urandom_range(0, 31);
      run_num(v, 1'b1, 1'b0, 32'd0);
    end

    // asynchronous reset during conversion
    s_rdy = 1'b1;
    offer(32'd123);
    @(negedge clk);
    n_vld = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_conv_s_vld", s_vld, 0);
    chk("rst_conv_n_rdy", n_rdy, 1);
    chk("rst_conv_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // asynchronous reset after three digits have been sent
    offer(32'd305419896);
    @(negedge clk);
    n_vld = 1'b0;
    w = 0;
    while (!s_vld && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("rst_send_reached", s_vld, 1);
    repeat (3) @(negedge clk);
    chk("rst_send_pre_vld", s_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_send_s_vld", s_vld, 0);
    chk("rst_send_n_rdy", n_rdy, 1);
    chk("rst_send_s_dtm", s_dtm, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_num($urandom, 1'b0, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
